// File: rtl/id_stage_pipe_pkg.sv
// Shared definitions for the instruction-decode stage: encodings, status bit
// indices, condition evaluation and control decode.
package id_stage_pipe_pkg;

  localparam logic [3:0] EXE_MOV = 4'b0001, EXE_ADD = 4'b0010, EXE_ADC = 4'b0011,
                         EXE_SUB = 4'b0100, EXE_SBC = 4'b0101, EXE_AND = 4'b0110,
                         EXE_ORR = 4'b0111, EXE_EOR = 4'b1000, EXE_MVN = 4'b1001;

  localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010,
                         OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110,
                         OP_TST = 4'b1000, OP_CMP = 4'b1010, OP_ORR = 4'b1100,
                         OP_MOV = 4'b1101, OP_MVN = 4'b1111;

  localparam logic [1:0] MODE_DP = 2'b00, MODE_MEM = 2'b01, MODE_BR = 2'b10;

  localparam logic [3:0] COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
                         COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
                         COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
                         COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14;

  localparam int SR_N = 3, SR_Z = 2, SR_C = 1, SR_V = 0;

  typedef struct packed {
    logic       s;
    logic       b;
    logic       mem_r;
    logic       mem_w;
    logic       wb;
    logic [3:0] exe_cmd;
  } ctrl_t;

  function automatic int reg_aw(int nreg);
    return ($clog2(nreg) < 4) ? 4 : $clog2(nreg);
  endfunction

  // Code 15 (NV) falls to the default and never passes.
  function automatic logic cond_pass(logic [3:0] cond, logic [3:0] sr);
    logic n, z, c, v, p;
    n = sr[SR_N];
    z = sr[SR_Z];
    c = sr[SR_C];
    v = sr[SR_V];
    case (cond)
      COND_EQ: p = z;
      COND_NE: p = ~z;
      COND_CS: p = c;
      COND_CC: p = ~c;
      COND_MI: p = n;
      COND_PL: p = ~n;
      COND_VS: p = v;
      COND_VC: p = ~v;
      COND_HI: p = c & ~z;
      COND_LS: p = ~c | z;
      COND_GE: p = (n == v);
      COND_LT: p = (n != v);
      COND_GT: p = ~z & (n == v);
      COND_LE: p = z | (n != v);
      COND_AL: p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  // S marks a flag-setting data-processing op; loads and stores reuse the
  // adder for address generation.
  function automatic ctrl_t decode_ctrl(logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[27:26])
      MODE_DP: begin
        c.s = instr[20];
        case (instr[24:21])
          OP_MOV:  begin c.exe_cmd = EXE_MOV; c.wb = 1'b1; end
          OP_MVN:  begin c.exe_cmd = EXE_MVN; c.wb = 1'b1; end
          OP_ADD:  begin c.exe_cmd = EXE_ADD; c.wb = 1'b1; end
          OP_ADC:  begin c.exe_cmd = EXE_ADC; c.wb = 1'b1; end
          OP_SUB:  begin c.exe_cmd = EXE_SUB; c.wb = 1'b1; end
          OP_SBC:  begin c.exe_cmd = EXE_SBC; c.wb = 1'b1; end
          OP_AND:  begin c.exe_cmd = EXE_AND; c.wb = 1'b1; end
          OP_ORR:  begin c.exe_cmd = EXE_ORR; c.wb = 1'b1; end
          OP_EOR:  begin c.exe_cmd = EXE_EOR; c.wb = 1'b1; end
          OP_CMP:  c.exe_cmd = EXE_SUB;
          OP_TST:  c.exe_cmd = EXE_AND;
          default: c.s = 1'b0;
        endcase
      end
      MODE_MEM: begin
        c.exe_cmd = EXE_ADD;
        if (instr[20]) begin
          c.mem_r = 1'b1;
          c.wb    = 1'b1;
        end else begin
          c.mem_w = 1'b1;
        end
      end
      MODE_BR: c.b = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// Bundle of fetch, write-back, hazard and execute-side signals of the decode stage.
interface id_stage_pipe_if
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16
);
  localparam int REG_AW = reg_aw(NREG);

  // Handshake: an instruction is taken on a rising edge when instr_valid and
  // instr_ready are both high; instr_ready depends only on stall and hazard.
  logic              instr_valid;
  logic [31:0]       instruction;
  logic [DATA_W-1:0] pc_in;
  logic              instr_ready;
  logic              wb_en;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic              hazard;
  logic              stall;
  logic              flush;
  logic [3:0]        sr;
  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;
  logic              two_src;
  logic              ex_valid;
  logic              ex_wb_en;
  logic              ex_mem_r_en;
  logic              ex_mem_w_en;
  logic              ex_b;
  logic              ex_s;
  logic [3:0]        ex_exe_cmd;
  logic [DATA_W-1:0] ex_val_rn;
  logic [DATA_W-1:0] ex_val_rm;
  logic [DATA_W-1:0] ex_pc;
  logic [REG_AW-1:0] ex_dest;
  logic              ex_imm;
  logic [11:0]       ex_shift_op;
  logic [23:0]       ex_simm24;

  modport master (
    output instr_valid, instruction, pc_in, wb_en, wb_dest, wb_value,
           hazard, stall, flush, sr,
    input  instr_ready, src1, src2, two_src, ex_valid, ex_wb_en, ex_mem_r_en,
           ex_mem_w_en, ex_b, ex_s, ex_exe_cmd, ex_val_rn, ex_val_rm, ex_pc,
           ex_dest, ex_imm, ex_shift_op, ex_simm24
  );

  modport slave (
    input  instr_valid, instruction, pc_in, wb_en, wb_dest, wb_value,
           hazard, stall, flush, sr,
    output instr_ready, src1, src2, two_src, ex_valid, ex_wb_en, ex_mem_r_en,
           ex_mem_w_en, ex_b, ex_s, ex_exe_cmd, ex_val_rn, ex_val_rm, ex_pc,
           ex_dest, ex_imm, ex_shift_op, ex_simm24
  );
endinterface

// File: rtl/id_regfile.sv
// Architectural register file: two asynchronous read ports, one write port,
// optional write-through from the write port to the readers.
module id_regfile #(
  parameter int NREG      = 16,
  parameter int DATA_W    = 32,
  parameter int BYPASS_EN = 1,
  parameter int REG_AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (int'(wr_addr) < NREG)) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) regs_q <= '{default: '0};
    else      regs_q <= regs_d;
  end

  // Addresses beyond NREG read as zero when REG_AW is wider than needed.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (int'(rd_addr1) < NREG) rd_data1 = regs_q[rd_addr1];
    if (int'(rd_addr2) < NREG) rd_data2 = regs_q[rd_addr2];
    if ((BYPASS_EN != 0) && wr_en && (wr_addr == rd_addr1)) rd_data1 = wr_data;
    if ((BYPASS_EN != 0) && wr_en && (wr_addr == rd_addr2)) rd_data2 = wr_data;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: operand read, condition check, control decode and the
// ID/EX pipeline register with flush/stall/hazard handling.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NREG      = 16,
  parameter int BYPASS_EN = 1
) (
  input logic          clk,
  input logic          rst,
  id_stage_pipe_if.slave bus
);
  localparam int REG_AW = reg_aw(NREG);

  ctrl_t             ctrl_raw, ctrl_ld, ctrl_d, ctrl_q;
  logic              kill;
  logic              valid_d, valid_q;
  logic [REG_AW-1:0] src1, src2, dest;
  logic [DATA_W-1:0] rn_data, rm_data;
  logic [DATA_W-1:0] val_rn_d, val_rn_q, val_rm_d, val_rm_q, pc_d, pc_q;
  logic [REG_AW-1:0] dest_d, dest_q;
  logic              imm_d, imm_q;
  logic [11:0]       shift_op_d, shift_op_q;
  logic [23:0]       simm24_d, simm24_q;

  // Stores read their data register through the second port.
  always_comb begin
    ctrl_raw  = decode_ctrl(bus.instruction);
    src1      = '0;
    src1[3:0] = bus.instruction[19:16];
    src2      = '0;
    src2[3:0] = ctrl_raw.mem_w ? bus.instruction[15:12] : bus.instruction[3:0];
    dest      = '0;
    dest[3:0] = bus.instruction[15:12];
    kill      = bus.hazard | ~cond_pass(bus.instruction[31:28], bus.sr) | ~bus.instr_valid;
    ctrl_ld   = kill ? '0 : ctrl_raw;
  end

  id_regfile #(
    .NREG(NREG), .DATA_W(DATA_W), .BYPASS_EN(BYPASS_EN), .REG_AW(REG_AW)
  ) u_regfile (
    .clk(clk), .rst(rst),
    .rd_addr1(src1), .rd_addr2(src2),
    .rd_data1(rn_data), .rd_data2(rm_data),
    .wr_en(bus.wb_en), .wr_addr(bus.wb_dest), .wr_data(bus.wb_value)
  );

  // Flush clears only controls; datapath fields are don't-care once invalid.
  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    val_rn_d   = val_rn_q;
    val_rm_d   = val_rm_q;
    pc_d       = pc_q;
    dest_d     = dest_q;
    imm_d      = imm_q;
    shift_op_d = shift_op_q;
    simm24_d   = simm24_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!bus.stall) begin
      valid_d    = ~kill;
      ctrl_d     = ctrl_ld;
      val_rn_d   = rn_data;
      val_rm_d   = rm_data;
      pc_d       = bus.pc_in;
      dest_d     = dest;
      imm_d      = bus.instruction[25];
      shift_op_d = bus.instruction[11:0];
      simm24_d   = bus.instruction[23:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      val_rn_q   <= '0;
      val_rm_q   <= '0;
      pc_q       <= '0;
      dest_q     <= '0;
      imm_q      <= 1'b0;
      shift_op_q <= '0;
      simm24_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      val_rn_q   <= val_rn_d;
      val_rm_q   <= val_rm_d;
      pc_q       <= pc_d;
      dest_q     <= dest_d;
      imm_q      <= imm_d;
      shift_op_q <= shift_op_d;
      simm24_q   <= simm24_d;
    end
  end

  assign bus.instr_ready = ~bus.stall & ~bus.hazard;
  assign bus.two_src     = ctrl_raw.mem_w | ~bus.instruction[25];
  assign bus.src1        = src1;
  assign bus.src2        = src2;
  assign bus.ex_valid    = valid_q;
  assign bus.ex_s        = ctrl_q.s;
  assign bus.ex_b        = ctrl_q.b;
  assign bus.ex_mem_r_en = ctrl_q.mem_r;
  assign bus.ex_mem_w_en = ctrl_q.mem_w;
  assign bus.ex_wb_en    = ctrl_q.wb;
  assign bus.ex_exe_cmd  = ctrl_q.exe_cmd;
  assign bus.ex_val_rn   = val_rn_q;
  assign bus.ex_val_rm   = val_rm_q;
  assign bus.ex_pc       = pc_q;
  assign bus.ex_dest     = dest_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_shift_op = shift_op_q;
  assign bus.ex_simm24   = simm24_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: a bypassing instance is checked against a queue of
// expected ID/EX contents; a non-bypassing twin shares the same stimulus.
module tb_id_stage_pipe;
  localparam int W = 147;
  localparam logic [31:0] I_ADD  = 32'hE0821003;
  localparam logic [8:0]  C_ADD  = {5'b00001, 4'b0010};
  localparam logic [8:0]  C_ADDS = {5'b10001, 4'b0010};
  localparam logic [8:0]  C_EOR  = {5'b00001, 4'b1000};
  localparam logic [8:0]  C_CMP  = {5'b10000, 4'b0100};
  localparam logic [8:0]  C_LDR  = {5'b00101, 4'b0010};
  localparam logic [8:0]  C_STR  = {5'b00010, 4'b0010};
  localparam logic [8:0]  C_B    = {5'b01000, 4'b0000};
  localparam logic [8:0]  C_MOV  = {5'b00001, 4'b0001};

  logic clk;
  logic rst;
  int vectors;
  int miscompares;
  logic [W-1:0] exp_q[$];
  logic [31:0] rf_model [16];

  id_stage_pipe_if #(.DATA_W(32), .NREG(16)) b1 ();
  id_stage_pipe_if #(.DATA_W(32), .NREG(16)) b0 ();

  id_stage_pipe #(.DATA_W(32), .NREG(16), .BYPASS_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  id_stage_pipe #(.DATA_W(32), .NREG(16), .BYPASS_EN(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  assign b0.instr_valid = b1.instr_valid;
  assign b0.instruction = b1.instruction;
  assign b0.pc_in       = b1.pc_in;
  assign b0.wb_en       = b1.wb_en;
  assign b0.wb_dest     = b1.wb_dest;
  assign b0.wb_value    = b1.wb_value;
  assign b0.hazard      = b1.hazard;
  assign b0.stall       = b1.stall;
  assign b0.flush       = b1.flush;
  assign b0.sr          = b1.sr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] obs();
    return {b1.ex_valid, b1.ex_s, b1.ex_b, b1.ex_mem_r_en, b1.ex_mem_w_en, b1.ex_wb_en,
            b1.ex_exe_cmd, b1.ex_val_rn, b1.ex_val_rm, b1.ex_dest, b1.ex_pc,
            b1.ex_imm, b1.ex_shift_op, b1.ex_simm24};
  endfunction

  function automatic logic [W-1:0] mk_exp(logic v, logic [8:0] c, logic [31:0] rn,
                                          logic [31:0] rm, logic [31:0] ins, logic [31:0] pc);
    logic [8:0] cc;
    cc = v ? c : 9'd0;
    return {v, cc, rn, rm, ins[15:12], pc, ins[25], ins[11:0], ins[23:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b1.instr_valid = 1'b0;
    b1.instruction = '0;
    b1.pc_in       = '0;
    b1.wb_en       = 1'b0;
    b1.wb_dest     = '0;
    b1.wb_value    = '0;
    b1.hazard      = 1'b0;
    b1.stall       = 1'b0;
    b1.flush       = 1'b0;
    b1.sr          = '0;
  endtask

  task automatic wb_write(logic [3:0] a, logic [31:0] v);
    b1.instr_valid = 1'b0;
    b1.wb_en = 1'b1;
    b1.wb_dest = a;
    b1.wb_value = v;
    step();
    b1.wb_en = 1'b0;
    rf_model[a] = v;
  endtask

  task automatic issue(logic [31:0] ins, logic [31:0] pc);
    b1.instr_valid = 1'b1;
    b1.instruction = ins;
    b1.pc_in = pc;
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    vectors++;
    if (obs() !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", obs());
    end
    rst = 1'b1;
    wb_write(4'd3, 32'h55);
    rst = 1'b0;
    issue(I_ADD, 32'h40);
    b1.wb_en = 1'b1; b1.wb_dest = 4'd3; b1.wb_value = 32'h99;
    b1.stall = 1'b1; b1.flush = 1'b1;
    step();
    for (int i = 0; i < 16; i++) rf_model[i] = '0;
    vectors++;
    if (obs() !== '0) begin
      miscompares++;
      $display("FAIL reset_override: got %h expected 0", obs());
    end
    rst = 1'b1;
    idle();
    issue(I_ADD, 32'h100);
    exp_q.push_back(mk_exp(1'b1, C_ADD, rf_model[2], rf_model[3], I_ADD, 32'h100));
    step();
    e = exp_q.pop_front();
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL reset_r3_read: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] e;
    wb_write(4'd2, 32'd5);
    wb_write(4'd3, 32'd7);
    issue(I_ADD, 32'h104);
    #1;
    vectors++;
    if ({b1.src1, b1.src2, b1.two_src, b1.instr_ready} !== {4'd2, 4'd3, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL add_comb: got %h expected %h",
               {b1.src1, b1.src2, b1.two_src, b1.instr_ready}, {4'd2, 4'd3, 1'b1, 1'b1});
    end
    exp_q.push_back(mk_exp(1'b1, C_ADD, 32'd5, 32'd7, I_ADD, 32'h104));
    step();
    e = exp_q.pop_front();
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL add: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] e;
    issue(I_ADD, 32'h108);
    b1.wb_en = 1'b1; b1.wb_dest = 4'd2; b1.wb_value = 32'h1234;
    exp_q.push_back(mk_exp(1'b1, C_ADD, 32'h1234, 32'd7, I_ADD, 32'h108));
    step();
    b1.wb_en = 1'b0;
    rf_model[2] = 32'h1234;
    e = exp_q.pop_front();
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL bypass_on: got %h expected %h", obs(), e);
    end
    vectors++;
    if (b0.ex_val_rn !== 32'd5) begin
      miscompares++;
      $display("FAIL bypass_off: got %h expected %h", b0.ex_val_rn, 32'd5);
    end
  endtask

  task automatic test_cond();
    logic [W-1:0] e;
    logic [31:0] ins;
    logic [3:0] cc  [12] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd8, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15};
    logic [3:0] srv [12] = '{4'b0000, 4'b0100, 4'b0100, 4'b0010, 4'b0110, 4'b1001,
                             4'b1000, 4'b0001, 4'b1000, 4'b0000, 4'b1111, 4'b0000};
    logic       ev  [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      ins = {cc[i], 28'h0821003};
      issue(ins, 32'h200 + 32'(4 * i));
      b1.sr = srv[i];
      exp_q.push_back(mk_exp(ev[i], C_ADD, rf_model[2], rf_model[3], ins, 32'h200 + 32'(4 * i)));
      step();
      e = exp_q.pop_front();
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL cond[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    b1.sr = '0;
  endtask

  task automatic test_decode();
    logic [W-1:0] e;
    logic [31:0] ins  [7] = '{32'hE0221003, 32'hE0921003, 32'hE1520003, 32'hE5954000,
                              32'hE5854000, 32'hEA000010, 32'hE3A00001};
    logic [8:0]  ctl  [7] = '{C_EOR, C_ADDS, C_CMP, C_LDR, C_STR, C_B, C_MOV};
    logic [3:0]  rn_i [7] = '{4'd2, 4'd2, 4'd2, 4'd5, 4'd5, 4'd0, 4'd0};
    logic [3:0]  rm_i [7] = '{4'd3, 4'd3, 4'd3, 4'd0, 4'd4, 4'd0, 4'd1};
    logic        ts   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    wb_write(4'd4, 32'h44);
    wb_write(4'd5, 32'h500);
    wb_write(4'd0, 32'h10);
    wb_write(4'd1, 32'h11);
    for (int i = 0; i < 7; i++) begin
      issue(ins[i], 32'h300 + 32'(4 * i));
      #1;
      vectors++;
      if ({b1.src1, b1.src2, b1.two_src} !== {rn_i[i], rm_i[i], ts[i]}) begin
        miscompares++;
        $display("FAIL decode_src[%0d]: got %h expected %h", i,
                 {b1.src1, b1.src2, b1.two_src}, {rn_i[i], rm_i[i], ts[i]});
      end
      exp_q.push_back(mk_exp(1'b1, ctl[i], rf_model[rn_i[i]], rf_model[rm_i[i]], ins[i],
                             32'h300 + 32'(4 * i)));
      step();
      e = exp_q.pop_front();
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL decode[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_stall_flush();
    logic [W-1:0] e;
    logic [W-1:0] held;
    issue(I_ADD, 32'h400);
    held = mk_exp(1'b1, C_ADD, rf_model[2], rf_model[3], I_ADD, 32'h400);
    exp_q.push_back(held);
    step();
    e = exp_q.pop_front();
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL stall_load: got %h expected %h", obs(), e);
    end
    b1.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(32'hE3A00001, 32'h500 + 32'(i));
      b1.sr = 4'(i + 5);
      b1.wb_en = (i == 0);
      b1.wb_dest = 4'd6;
      b1.wb_value = 32'h66;
      #1;
      vectors++;
      if (b1.instr_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_ready[%0d]: got %b expected 0", i, b1.instr_ready);
      end
      exp_q.push_back(held);
      step();
      e = exp_q.pop_front();
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    b1.wb_en = 1'b0;
    rf_model[6] = 32'h66;
    b1.sr = '0;
    b1.flush = 1'b1;
    exp_q.push_back(mk_exp(1'b0, C_ADD, rf_model[2], rf_model[3], I_ADD, 32'h400));
    step();
    e = exp_q.pop_front();
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL flush_stall: got %h expected %h", obs(), e);
    end
    b1.flush = 1'b0;
    b1.stall = 1'b0;
    issue(32'hE0861003, 32'h600);
    exp_q.push_back(mk_exp(1'b1, C_ADD, 32'h66, rf_model[3], 32'hE0861003, 32'h600));
    step();
    e = exp_q.pop_front();
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL stall_wb: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_hazard();
    logic [W-1:0] e;
    issue(I_ADD, 32'h700);
    b1.hazard = 1'b1;
    #1;
    vectors++;
    if (b1.instr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL hazard_ready: got %b expected 0", b1.instr_ready);
    end
    exp_q.push_back(mk_exp(1'b0, C_ADD, rf_model[2], rf_model[3], I_ADD, 32'h700));
    step();
    e = exp_q.pop_front();
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL hazard_bubble: got %h expected %h", obs(), e);
    end
    b1.hazard = 1'b0;
    b1.instr_valid = 1'b0;
    b1.pc_in = 32'h704;
    exp_q.push_back(mk_exp(1'b0, C_ADD, rf_model[2], rf_model[3], I_ADD, 32'h704));
    step();
    e = exp_q.pop_front();
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL invalid_bubble: got %h expected %h", obs(), e);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 16; i++) rf_model[i] = '0;
    rst = 1'b0;
    idle();
    step();
    step();
    test_reset();
    test_add();
    test_bypass();
    test_cond();
    test_decode();
    test_stall_flush();
    test_hazard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter DATA_W, 32, register/operand data width.
REQ-002 Parameter NREG, 16, architectural register count; REG_AW = clog2(NREG), min 4.
REQ-003 Parameter BYPASS_EN, 1, enables WB-to-read write-through bypass.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-low.
REQ-006 instr_valid  in  1 / instruction  in  32 / pc_in  in  DATA_W  fetched instruction and its PC.
REQ-007 instr_ready  out  1  high when the stage accepts an instruction this cycle.
REQ-008 wb_en  in  1 / wb_dest  in  REG_AW / wb_value  in  DATA_W  write-back port.
REQ-009 hazard  in  1 / stall  in  1 / flush  in  1  hazard-unit bubble, downstream hold, branch kill.
REQ-010 sr  in  4  status {N,Z,C,V}, bit3..bit0.
REQ-011 src1, src2  out  REG_AW  combinational read addresses; two_src  out  1  combinational.
REQ-012 ex_valid  out  1 / ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s  out  1 / ex_exe_cmd  out  4  registered controls.
REQ-013 ex_val_rn, ex_val_rm, ex_pc  out  DATA_W / ex_dest  out  REG_AW / ex_imm  out  1 / ex_shift_op  out  12 / ex_simm24  out  24  registered datapath.

Function
REQ-014 src1 = instruction[19:16]; src2 = instruction[15:12] when decoded mem-write (STR), else instruction[3:0]; upper address bits zero-extended.
REQ-015 two_src = decoded mem_w_en OR NOT instruction[25]; computed from raw decode, independent of hazard/condition.
REQ-016 Register file: NREG x DATA_W, 2 async read ports, 1 write port written on rising edge when wb_en and rst high.
REQ-017 With BYPASS_EN=1, a read whose address equals wb_dest while wb_en=1 returns wb_value the same cycle; with 0, returns old contents.
REQ-018 Condition check over instruction[31:28] codes 0-14 per ARM EQ..AL; code 15 evaluates false.
REQ-019 Control decode from instruction[27:26], [24:21], [20] yields {S,B,mem_r,mem_w,wb,exe_cmd}; MOV/MVN/ADD/ADC/SUB/SBC/AND/ORR/EOR/CMP/TST/LDR/STR/B per team encoding.
REQ-020 kill = hazard OR NOT cond_pass OR NOT instr_valid; when kill, all registered controls load zero and ex_valid loads 0; datapath fields load normally.
REQ-021 instr_ready = NOT stall AND NOT hazard.
REQ-022 Register update priority per cycle: reset > flush > stall > load.
REQ-023 flush: ex_valid and all ex_ control outputs cleared next cycle, even if stall is high.
REQ-024 stall (no flush): every ex_ output holds its value; register file writes still occur.
REQ-025 load: ex_ outputs capture current decode; latency instruction-to-ex_ outputs = 1 cycle.
REQ-026 Condition uses sr sampled in the load cycle; sr changes during stall do not alter held outputs.
REQ-027 wb write to register N coincident with load reading N captures wb_value only if BYPASS_EN=1.

Reset
REQ-028 rst low at rising edge: all ex_ outputs zero, ex_valid 0, all NREG registers zero.
REQ-029 Reset overrides concurrent wb_en write, stall and flush; outputs valid from first edge after rst returns high.

Structure
REQ-030 Shared package holds exe_cmd encodings, opcode constants, condition-code constants, status bit indices.
REQ-031 One sub-module: id_regfile (parametrised NREG, DATA_W, BYPASS_EN); condition check and control decode are functions in the package.

Verification
REQ-032 Reset: write R3=0x55 then rst low one cycle -> R3 reads 0, ex_valid 0.
REQ-033 ADD R1,R2,R3 (0xE0821003), R2=5, R3=7 -> next cycle ex_valid 1, ex_exe_cmd ADD, ex_val_rn 5, ex_val_rm 7, ex_dest 1.
REQ-034 Bypass: wb_en with R2=0x1234 same cycle as read of R2 -> ex_val_rn 0x1234 (BYPASS_EN=1), old value (BYPASS_EN=0).
REQ-035 ADDEQ with sr Z=0 -> ex_valid 0, controls zero; with Z=1 -> ex_valid 1.
REQ-036 stall 3 cycles after load -> ex_ outputs unchanged, instr_ready 0; flush+stall together -> ex_valid 0 next cycle.
REQ-037 STR R4,[R5] -> src2 = 4, two_src 1; MOV R0,#1 -> two_src 0.
